// File: rtl/add_pipe2.sv
// Two-stage pipelined add/subtract with valid/ready on both ports.
// Stage 1 adds the low half and registers its carry; stage 2 adds the high half.
module add_pipe2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_overflow
);

    localparam int H = WIDTH / 2;

    logic [WIDTH-1:0] b_eff_s;
    logic [H:0]       lo_sum_s;
    logic [H:0]       hi_sum_s;
    logic [WIDTH-1:0] sum_s;
    logic             ovf_s;
    logic             adv2_s;
    logic             in_ready_s;
    logic             load1_s;

    logic             s1_valid_r;
    logic [H-1:0]     s1_lo_r;
    logic             s1_c_lo_r;
    logic [H-1:0]     s1_a_hi_r;
    logic [H-1:0]     s1_b_hi_r;
    logic             s1_a_msb_r;
    logic             s1_b_msb_r;

    logic             out_valid_r;
    logic [WIDTH-1:0] out_sum_r;
    logic             out_carry_r;
    logic             out_overflow_r;

    // Operand preparation and low-half add; subtract is A + ~B + 1.
    always_comb begin
        if (in_sub) begin
            b_eff_s = ~in_b;
        end else begin
            b_eff_s = in_b;
        end
        lo_sum_s = {1'b0, in_a[H-1:0]} + {1'b0, b_eff_s[H-1:0]} + {{H{1'b0}}, in_sub};
    end

    // High-half add from registered carry, and signed overflow detection.
    always_comb begin
        hi_sum_s = {1'b0, s1_a_hi_r} + {1'b0, s1_b_hi_r} + {{H{1'b0}}, s1_c_lo_r};
        sum_s    = {hi_sum_s[H-1:0], s1_lo_r};
        ovf_s    = (s1_a_msb_r == s1_b_msb_r) && (sum_s[WIDTH-1] != s1_a_msb_r);
    end

    // Handshake: stage 2 frees when empty or drained; stage 1 frees when empty or stage 2 frees.
    always_comb begin
        adv2_s     = !out_valid_r || out_ready;
        in_ready_s = !s1_valid_r || adv2_s;
        load1_s    = in_ready_s && in_valid;
    end

    // Stage-1 register: valid flag follows in_valid whenever the stage can accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r <= 1'b0;
            s1_lo_r    <= '0;
            s1_c_lo_r  <= 1'b0;
            s1_a_hi_r  <= '0;
            s1_b_hi_r  <= '0;
            s1_a_msb_r <= 1'b0;
            s1_b_msb_r <= 1'b0;
        end else begin
            if (in_ready_s) begin
                s1_valid_r <= in_valid;
            end
            if (load1_s) begin
                s1_lo_r    <= lo_sum_s[H-1:0];
                s1_c_lo_r  <= lo_sum_s[H];
                s1_a_hi_r  <= in_a[WIDTH-1:H];
                s1_b_hi_r  <= b_eff_s[WIDTH-1:H];
                s1_a_msb_r <= in_a[WIDTH-1];
                s1_b_msb_r <= b_eff_s[WIDTH-1];
            end
        end
    end

    // Output register: holds steady while stalled, otherwise takes stage 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r    <= 1'b0;
            out_sum_r      <= '0;
            out_carry_r    <= 1'b0;
            out_overflow_r <= 1'b0;
        end else if (adv2_s) begin
            out_valid_r    <= s1_valid_r;
            out_sum_r      <= sum_s;
            out_carry_r    <= hi_sum_s[H];
            out_overflow_r <= ovf_s;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = out_valid_r;
    assign out_sum      = out_sum_r;
    assign out_carry    = out_carry_r;
    assign out_overflow = out_overflow_r;

endmodule
